int_controller: RTL

Interrupt controller that drives the CPU's interrupt inputs (`int_req`, `int_en`, `int_vec`) and captures the CPU's `ret_addr` when an interrupt is taken. It collects four peripheral interrupt sources and latches their rising edges as pending bits. It arbitrates by fixed priority and issues a single-cycle request, then blocks further requests until software writes end-of-interrupt. Software sees it as six memory-mapped byte registers on the data bus.

---
 rtl/int_ctrl_pkg.sv | 35 +++
 rtl/irq_edge_detect.sv | 20 ++
 rtl/int_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants, state type and priority helper for the interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned NSRC = 4;

    localparam logic [7:0] INT_EN_OFS   = 8'd0;
    localparam logic [7:0] INT_VEC_OFS  = 8'd1;
    localparam logic [7:0] PENDING_OFS  = 8'd2;
    localparam logic [7:0] STATUS_OFS   = 8'd3;
    localparam logic [7:0] RET_SAVE_OFS = 8'd4;
    localparam logic [7:0] EOI_OFS      = 8'd5;
    localparam logic [7:0] NREGS        = 8'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Lowest-index set bit wins.
    function automatic logic [1:0] prio_pick(input logic [NSRC-1:0] req);
        logic [1:0] pick;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (req[i] && !found) begin
                pick  = 2'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Per-source rising-edge detector: registers the previous level of each line.
module irq_edge_detect
    import int_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    output logic [NSRC-1:0] rise
);

    logic [NSRC-1:0] prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= irq_src;
    end

    assign rise = irq_src & ~prev;

endmodule

// File: rtl/int_controller.sv
// Four-source interrupt controller: pending latch, fixed-priority arbiter,
// one-cycle CPU request and memory-mapped byte register block.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter logic [7:0] VEC_RESET = 8'h00
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    output logic            int_req,
    output logic [7:0]      int_en,
    output logic [7:0]      int_vec,
    input  logic [7:0]      ret_addr,
    input  logic [7:0]      addr,
    input  logic [7:0]      w_data,
    input  logic            w_en,
    output logic [7:0]      r_data
);

    state_t          state_q, state_d;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] grant_clr;
    logic [NSRC-1:0] w1c_clr;
    logic [1:0]      winner;
    logic [1:0]      id;
    logic            in_service;
    logic [7:0]      ret_save;
    logic [7:0]      ofs;
    logic            hit;
    logic            take;
    logic            eoi_wr;

    irq_edge_detect u_edge (
        .clock   (clock),
        .reset   (reset),
        .irq_src (irq_src),
        .rise    (rise)
    );

    assign ofs      = addr - BASE_ADDR;
    assign hit      = (addr >= BASE_ADDR) && (ofs < NREGS);
    assign eligible = pending & int_en[4:1];
    assign winner   = prio_pick(eligible);
    assign eoi_wr   = w_en && hit && (ofs == EOI_OFS);
    assign take     = (state_q == IDLE) && (state_d == REQ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (int_en[0] && |eligible) state_d = REQ;
            REQ:     state_d = SERVICE;
            SERVICE: if (eoi_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int_req = (state_q == REQ);
    end

    // New edges are OR'd in after both clear sources, so a set always wins.
    always_comb begin
        grant_clr = '0;
        if (take) grant_clr[winner] = 1'b1;
        w1c_clr = '0;
        if (w_en && hit && (ofs == PENDING_OFS)) w1c_clr = w_data[NSRC-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            id         <= '0;
            in_service <= 1'b0;
            ret_save   <= '0;
            int_en     <= '0;
            int_vec    <= VEC_RESET;
        end else begin
            pending <= (pending & ~grant_clr & ~w1c_clr) | rise;
            if (take) begin
                id         <= winner;
                in_service <= 1'b1;
            end else if (eoi_wr && (state_q == SERVICE)) begin
                in_service <= 1'b0;
            end
            if (state_q == REQ) ret_save <= ret_addr;
            if (w_en && hit && (ofs == INT_EN_OFS))  int_en  <= w_data;
            if (w_en && hit && (ofs == INT_VEC_OFS)) int_vec <= w_data;
        end
    end

    always_comb begin
        r_data = '0;
        if (hit) begin
            case (ofs)
                INT_EN_OFS:   r_data = int_en;
                INT_VEC_OFS:  r_data = int_vec;
                PENDING_OFS:  r_data = {4'b0, pending};
                STATUS_OFS:   r_data = {in_service, 5'b0, id};
                RET_SAVE_OFS: r_data = ret_save;
                default:      r_data = '0;
            endcase
        end
    end

endmodule
